jts16_scr_mmr: RTL and testbench

CPU-facing memory-mapped register bank that produces the `pages`, `hscr` and `vscr` words consumed by the two scroll tilemap layers (foreground and background). It decodes 68000 word writes with byte strobes and provides registered readback. Double-buffered values are committed to the layers at the start of vertical blank, so a frame never renders with mixed scroll settings. It sits between the CPU bus decoder and the scroll layer instances.

---
 rtl/jts16_scr_mmr_if.sv | 34 +++
 rtl/jts16_scr_mmr.sv | 172 +++++++++++++++++
 tb/tb_jts16_scr_mmr.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/jts16_scr_mmr_if.sv
// CPU-side register window bus for jts16_scr_mmr.
// Carries a 68000-style word access: chip select held for the whole access,
// word index, read/not-write, active-low byte strobes, write data and the
// registered read data returned by the register bank.
// Handshake: an access begins on the first cycle cs is sampled high. A write
// is taken once per cs assertion (rising edge of cs). A read returns dout on
// the clock edge after cs & rnw is sampled. There is no ready/wait signal;
// the bank accepts every access at full rate.
interface jts16_scr_mmr_if;
  logic        cs;
  logic [2:0]  addr;
  logic        rnw;
  logic [1:0]  dsn;
  logic [15:0] din;
  logic [15:0] dout;

  modport master (
    output cs,
    output addr,
    output rnw,
    output dsn,
    output din,
    input  dout
  );

  modport slave (
    input  cs,
    input  addr,
    input  rnw,
    input  dsn,
    input  din,
    output dout
  );
endinterface

// File: rtl/jts16_scr_mmr.sv
// Scroll tilemap register bank for the foreground and background layers.
// Decodes CPU word writes with byte strobes into pages/hscr/vscr/flip and
// provides registered readback plus a status word (pending flag and frame
// counter).
// Optional feature macro: JTS16_MMR_SHADOW_EN. When defined, CPU writes land
// in a shadow copy that is committed to the layers on the rising edge of
// vblank, so a frame never renders with mixed settings. When undefined, the
// layer registers are written directly.
// Register map: 0 fg_pages, 1 bg_pages, 2 fg_hscr, 3 bg_hscr, 4 fg_vscr,
// 5 bg_vscr, 6 ctrl (bit 0 flip), 7 status (read-only).
module jts16_scr_mmr #(
  parameter logic [15:0] PAGE_RST = 16'h0000,
  parameter logic [15:0] SCR_RST  = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  jts16_scr_mmr_if.slave     bus,
  input  logic               vblank,
  output logic [15:0]        fg_pages,
  output logic [15:0]        fg_hscr,
  output logic [15:0]        fg_vscr,
  output logic [15:0]        bg_pages,
  output logic [15:0]        bg_hscr,
  output logic [15:0]        bg_vscr,
  output logic               flip
);

  localparam int NREG = 6;

  // Indices 0 and 1 are page registers, the rest are scroll registers.
  function automatic logic [15:0] rst_val(input int idx);
    return (idx < 2) ? PAGE_RST : SCR_RST;
  endfunction

  // Byte-lane merge: a lane is replaced only when its active-low strobe is 0.
  function automatic logic [15:0] merge(input logic [15:0] old_v,
                                        input logic [15:0] new_v,
                                        input logic [1:0]  ds);
    logic [15:0] r;
    r = old_v;
    if (!ds[1]) r[15:8] = new_v[15:8];
    if (!ds[0]) r[7:0]  = new_v[7:0];
    return r;
  endfunction

  logic        cs_l_q, cs_l_d;
  logic        vb_l_q, vb_l_d;
  logic        wr_stb_q, wr_stb_d;
  logic [2:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_din_q, wr_din_d;
  logic [1:0]  wr_dsn_q, wr_dsn_d;
  logic [7:0]  frame_q, frame_d;
  logic        pending_q, pending_d;
  logic [15:0] dout_q, dout_d;
  logic [15:0] live_q [NREG];
  logic [15:0] live_d [NREG];
  logic        flip_q, flip_d;
`ifdef JTS16_MMR_SHADOW_EN
  logic [15:0] sh_q [NREG];
  logic [15:0] sh_d [NREG];
  logic        sh_flip_q, sh_flip_d;
`endif

  logic        commit;
  logic [15:0] rd_src [NREG];
  logic        rd_flip;
  logic [15:0] rd_val;

  // Next-state logic: write capture, commit, register update and readback.
  always_comb begin
    cs_l_d    = bus.cs;
    vb_l_d    = vblank;
    commit    = vblank & ~vb_l_q;
    // One strobe per access: only the first cycle cs is seen high.
    wr_stb_d  = bus.cs & ~cs_l_q & ~bus.rnw;
    wr_addr_d = wr_addr_q;
    wr_din_d  = wr_din_q;
    wr_dsn_d  = wr_dsn_q;
    if (wr_stb_d) begin
      wr_addr_d = bus.addr;
      wr_din_d  = bus.din;
      wr_dsn_d  = bus.dsn;
    end
    frame_d   = frame_q + {7'd0, commit};
    pending_d = pending_q;
    flip_d    = flip_q;
    for (int i = 0; i < NREG; i++) live_d[i] = live_q[i];
`ifdef JTS16_MMR_SHADOW_EN
    sh_flip_d = sh_flip_q;
    for (int i = 0; i < NREG; i++) sh_d[i] = sh_q[i];
    // Commit uses the pre-write shadow; a coincident write stays pending.
    if (commit) begin
      for (int i = 0; i < NREG; i++) live_d[i] = sh_q[i];
      flip_d    = sh_flip_q;
      pending_d = 1'b0;
    end
    if (wr_stb_q) begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_addr_q == 3'(i)) sh_d[i] = merge(sh_q[i], wr_din_q, wr_dsn_q);
      end
      if (wr_addr_q == 3'd6 && !wr_dsn_q[0]) sh_flip_d = wr_din_q[0];
      if (wr_addr_q != 3'd7) pending_d = 1'b1;
    end
    for (int i = 0; i < NREG; i++) rd_src[i] = sh_q[i];
    rd_flip = sh_flip_q;
`else
    pending_d = 1'b0;
    if (wr_stb_q) begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_addr_q == 3'(i)) live_d[i] = merge(live_q[i], wr_din_q, wr_dsn_q);
      end
      if (wr_addr_q == 3'd6 && !wr_dsn_q[0]) flip_d = wr_din_q[0];
    end
    for (int i = 0; i < NREG; i++) rd_src[i] = live_q[i];
    rd_flip = flip_q;
`endif
    rd_val = 16'h0000;
    for (int i = 0; i < NREG; i++) begin
      if (bus.addr == 3'(i)) rd_val = rd_src[i];
    end
    if (bus.addr == 3'd6) rd_val = {15'd0, rd_flip};
    if (bus.addr == 3'd7) rd_val = {pending_q, 7'd0, frame_q};
    dout_d = (bus.cs & bus.rnw) ? rd_val : dout_q;
  end

  // State registers with synchronous reset; reset also drops any pending strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_l_q    <= 1'b0;
      vb_l_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= 3'd0;
      wr_din_q  <= 16'h0000;
      wr_dsn_q  <= 2'b11;
      frame_q   <= 8'd0;
      pending_q <= 1'b0;
      dout_q    <= 16'h0000;
      flip_q    <= 1'b0;
      for (int i = 0; i < NREG; i++) live_q[i] <= rst_val(i);
`ifdef JTS16_MMR_SHADOW_EN
      sh_flip_q <= 1'b0;
      for (int i = 0; i < NREG; i++) sh_q[i] <= rst_val(i);
`endif
    end else begin
      cs_l_q    <= cs_l_d;
      vb_l_q    <= vb_l_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_din_q  <= wr_din_d;
      wr_dsn_q  <= wr_dsn_d;
      frame_q   <= frame_d;
      pending_q <= pending_d;
      dout_q    <= dout_d;
      flip_q    <= flip_d;
      for (int i = 0; i < NREG; i++) live_q[i] <= live_d[i];
`ifdef JTS16_MMR_SHADOW_EN
      sh_flip_q <= sh_flip_d;
      for (int i = 0; i < NREG; i++) sh_q[i] <= sh_d[i];
`endif
    end
  end

  assign fg_pages = live_q[0];
  assign bg_pages = live_q[1];
  assign fg_hscr  = live_q[2];
  assign bg_hscr  = live_q[3];
  assign fg_vscr  = live_q[4];
  assign bg_vscr  = live_q[5];
  assign flip     = flip_q;
  assign bus.dout = dout_q;

endmodule

// File: tb/tb_jts16_scr_mmr.sv
// Bench for jts16_scr_mmr: directed CPU accesses and vblank pulses, with a
// scoreboard queue of expected values checked by a separate monitor.
// Expectations follow JTS16_MMR_SHADOW_EN (same macro as the design build).
module tb_jts16_scr_mmr;

  logic        clk;
  logic        rst;
  logic        vblank;
  logic [15:0] fg_pages, fg_hscr, fg_vscr, bg_pages, bg_hscr, bg_vscr;
  logic        flip;

  jts16_scr_mmr_if bus ();

  jts16_scr_mmr #(
    .PAGE_RST (16'h3210),
    .SCR_RST  (16'h0000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .vblank   (vblank),
    .fg_pages (fg_pages),
    .fg_hscr  (fg_hscr),
    .fg_vscr  (fg_vscr),
    .bg_pages (bg_pages),
    .bg_hscr  (bg_hscr),
    .bg_vscr  (bg_vscr),
    .flip     (flip)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Scoreboard: sel 0 = dout, 1..6 = layer words, 7 = flip.
  logic [15:0] exp_q[$];
  int          sel_q[$];
  string       name_q[$];
  int          snap_n = 0;
  int          n_vec  = 0;
  int          n_err  = 0;
  logic        rd_seen = 1'b0;

  function automatic logic [15:0] actual(input int sel);
    case (sel)
      0: return bus.dout;
      1: return fg_pages;
      2: return bg_pages;
      3: return fg_hscr;
      4: return bg_hscr;
      5: return fg_vscr;
      6: return bg_vscr;
      default: return {15'd0, flip};
    endcase
  endfunction

  task automatic check_front();
    logic [15:0] e, a;
    int          s;
    string       nm;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_output: no expected entry, got %h", bus.dout);
    end else begin
      e  = exp_q.pop_front();
      s  = sel_q.pop_front();
      nm = name_q.pop_front();
      a  = actual(s);
      if (a !== e) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", nm, a, e);
      end
    end
  endtask

  // Monitor: a read sampled on the last posedge presents dout now.
  always @(posedge clk) rd_seen <= bus.cs & bus.rnw & ~rst;

  always @(negedge clk) begin
    if (rd_seen) check_front();
    while (snap_n > 0) begin
      check_front();
      snap_n--;
    end
  end

  // Driver tasks.
  task automatic push(input int sel, input logic [15:0] e, input string nm);
    exp_q.push_back(e);
    sel_q.push_back(sel);
    name_q.push_back(nm);
  endtask

  task automatic snap(input int sel, input logic [15:0] e, input string nm);
    push(sel, e, nm);
    snap_n++;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] e, input string nm);
    @(posedge clk); #1;
    bus.cs = 1'b1; bus.rnw = 1'b1; bus.addr = a;
    push(0, e, nm);
    @(posedge clk); #1;
    bus.cs = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic [15:0] d2,
                    input logic [1:0] ds, input int hold);
    @(posedge clk); #1;
    bus.cs = 1'b1; bus.rnw = 1'b0; bus.addr = a; bus.din = d; bus.dsn = ds;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      bus.din = d2;
    end
    bus.cs = 1'b0; bus.rnw = 1'b1; bus.dsn = 2'b11;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic pulse();
    @(posedge clk); #1 vblank = 1'b1;
    @(posedge clk); #1 vblank = 1'b0;
    @(posedge clk); #1;
  endtask

  // Stimulus.
  initial begin
    rst = 1'b1; vblank = 1'b0;
    bus.cs = 1'b0; bus.rnw = 1'b1; bus.addr = 3'd0; bus.dsn = 2'b11; bus.din = 16'h0000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values.
    snap(1, 16'h3210, "rst_fg_pages");
    snap(2, 16'h3210, "rst_bg_pages");
    snap(3, 16'h0000, "rst_fg_hscr");
    snap(4, 16'h0000, "rst_bg_hscr");
    snap(5, 16'h0000, "rst_fg_vscr");
    snap(6, 16'h0000, "rst_bg_vscr");
    snap(7, 16'h0000, "rst_flip");
    snap(0, 16'h0000, "rst_dout");
    rd(3'd7, 16'h0000, "rst_status");

    // Lower-lane write to fg_hscr.
    wr(3'd2, 16'hABCD, 16'h0000, 2'b10, 1);
`ifdef JTS16_MMR_SHADOW_EN
    snap(3, 16'h0000, "t2_live_hold");
    rd(3'd2, 16'h00CD, "t2_shadow");
    rd(3'd7, 16'h8000, "t2_pending");
    pulse();
    snap(3, 16'h00CD, "t2_live_commit");
    rd(3'd7, 16'h0001, "t2_status");
`else
    snap(3, 16'h00CD, "t2_live_direct");
    rd(3'd7, 16'h0000, "t2_status_pre");
    pulse();
    rd(3'd7, 16'h0001, "t2_status");
`endif

    // Long cs hold: only the first cycle's data may be taken.
    wr(3'd4, 16'h1234, 16'hDEAD, 2'b00, 5);
`ifdef JTS16_MMR_SHADOW_EN
    snap(5, 16'h0000, "t3_live_hold");
    rd(3'd4, 16'h1234, "t3_shadow");
`endif
    pulse();
    snap(5, 16'h1234, "t3_fg_vscr");
    rd(3'd7, 16'h0002, "t3_status");

    // Write strobe coincident with commit.
    wr(3'd3, 16'h0011, 16'h0000, 2'b00, 1);
    pulse();
    snap(4, 16'h0011, "t4_prior");
    @(posedge clk); #1;
    bus.cs = 1'b1; bus.rnw = 1'b0; bus.addr = 3'd3; bus.din = 16'h0055; bus.dsn = 2'b00;
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.rnw = 1'b1; bus.dsn = 2'b11; vblank = 1'b1;
    @(posedge clk); #1 vblank = 1'b0;
    @(posedge clk); #1;
`ifdef JTS16_MMR_SHADOW_EN
    snap(4, 16'h0011, "t4_same_live");
    rd(3'd3, 16'h0055, "t4_same_shadow");
    rd(3'd7, 16'h8004, "t4_same_status");
    pulse();
    snap(4, 16'h0055, "t4_next_commit");
`else
    snap(4, 16'h0055, "t4_same_live");
    rd(3'd7, 16'h0004, "t4_same_status");
    pulse();
    snap(4, 16'h0055, "t4_next_commit");
`endif
    rd(3'd7, 16'h0005, "t4_status");

    // Frame counter wrap and read-only status.
    repeat (250) pulse();
    rd(3'd7, 16'h00FF, "t5_pre_wrap");
    pulse();
    rd(3'd7, 16'h0000, "t5_wrap");
    wr(3'd7, 16'hFFFF, 16'hFFFF, 2'b00, 1);
    rd(3'd7, 16'h0000, "t5_status_ro");
    snap(1, 16'h3210, "t5_fg_pages_kept");

    // Flip via ctrl; other ctrl bits read 0.
    @(posedge clk); #1;
    bus.cs = 1'b1; bus.rnw = 1'b0; bus.addr = 3'd6; bus.din = 16'hFFFF; bus.dsn = 2'b00;
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.rnw = 1'b1; bus.dsn = 2'b11;
    snap(7, 16'h0000, "t6_flip_strobe_cycle");
    @(posedge clk); #1;
`ifdef JTS16_MMR_SHADOW_EN
    snap(7, 16'h0000, "t6_flip_hold");
    rd(3'd6, 16'h0001, "t6_ctrl_read");
    pulse();
    snap(7, 16'h0001, "t6_flip_commit");
`else
    snap(7, 16'h0001, "t6_flip_direct");
    rd(3'd6, 16'h0001, "t6_ctrl_read");
`endif

    // Upper-lane only write to fg_pages.
    wr(3'd0, 16'h5AA5, 16'h0000, 2'b01, 1);
    pulse();
    rd(3'd0, 16'h5A10, "t7_upper_lane_rd");
    snap(1, 16'h5A10, "t7_upper_lane_live");

    // dout holds while cs is low and across writes.
    @(posedge clk); #1;
    snap(0, 16'h5A10, "t8_dout_hold");
    wr(3'd5, 16'h0F0F, 16'h0F0F, 2'b00, 1);
    snap(0, 16'h5A10, "t8_dout_after_wr");
    rd(3'd5, 16'h0F0F, "t8_rd_bg_vscr");

    // Reset mid-access aborts the write; vblank high at release commits.
    @(posedge clk); #1;
    bus.cs = 1'b1; bus.rnw = 1'b0; bus.addr = 3'd1; bus.din = 16'hBEEF; bus.dsn = 2'b00;
    @(posedge clk); #1;
    rst = 1'b1; vblank = 1'b1;
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.rnw = 1'b1; bus.dsn = 2'b11;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    vblank = 1'b0;
    snap(2, 16'h3210, "t9_bg_pages_abort");
    rd(3'd1, 16'h3210, "t9_shadow_abort");
    rd(3'd7, 16'h0001, "t9_commit_on_release");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
